// File: rtl/conf_reg_bank.sv
// conf_reg_bank
//   Turns the UART receiver byte stream into committed configuration
//   parameters for the DRSSTC timing logic. A frame is PAR_NUM parameter
//   bytes followed by one XOR checksum byte. A frame is staged in shadow
//   registers and copied to par_bus in a single cycle only when the
//   checksum matches, so downstream logic never sees a half-written set.
//   A frame that stalls for longer than TIMEOUT_MAX cycles between bytes
//   is dropped, so the byte-count framing realigns after a link glitch.
//
// Ports
//   clk           system clock
//   rst           synchronous active-high reset
//   data_in       received byte, qualified by data_valid
//   data_valid    one-cycle strobe per received byte
//   par_bus       committed parameters, par k at [k*DATA_W +: DATA_W]
//   par_valid     high once any frame has committed since reset
//   upd_pulse     one-cycle pulse, par_bus was just updated
//   crc_err_pulse one-cycle pulse, checksum mismatch, frame dropped
//   to_pulse      one-cycle pulse, inter-byte timeout, frame dropped
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for the first byte of a frame
// COLLECT | storing parameter bytes, then waiting for the checksum byte
// CHECK   | one cycle: compare checksum, commit or flag the error

module conf_reg_bank #(
  parameter int DATA_W      = 8,
  parameter int PAR_NUM     = 5,
  parameter int TIMEOUT_MAX = 2048,
  parameter logic [PAR_NUM*DATA_W-1:0] PAR_DEFAULT = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         data_in,
  input  logic                      data_valid,
  output logic [PAR_NUM*DATA_W-1:0] par_bus,
  output logic                      par_valid,
  output logic                      upd_pulse,
  output logic                      crc_err_pulse,
  output logic                      to_pulse
);

  localparam int TO_W  = $clog2(TIMEOUT_MAX + 1);
  localparam int CNT_W = $clog2(PAR_NUM + 1);

  localparam logic [TO_W-1:0]  TO_LIMIT  = TO_W'(TIMEOUT_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PAR_NUM);
  localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    CHECK   = 2'd2
  } state_t;

  state_t                    state;
  logic [CNT_W-1:0]          byte_cnt;
  logic [DATA_W-1:0]         xor_acc;
  logic [DATA_W-1:0]         chk_reg;
  logic [TO_W-1:0]           timeout_cnt;
  logic [PAR_NUM*DATA_W-1:0] shadow;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      byte_cnt      <= '0;
      xor_acc       <= '0;
      chk_reg       <= '0;
      timeout_cnt   <= '0;
      shadow        <= '0;
      par_bus       <= PAR_DEFAULT;
      par_valid     <= 1'b0;
      upd_pulse     <= 1'b0;
      crc_err_pulse <= 1'b0;
      to_pulse      <= 1'b0;
    end else begin
      upd_pulse     <= 1'b0;
      crc_err_pulse <= 1'b0;
      to_pulse      <= 1'b0;

      case (state)
        IDLE: begin
          if (data_valid) begin
            shadow[0 +: DATA_W] <= data_in;
            xor_acc             <= data_in;
            byte_cnt            <= CNT_FIRST;
            timeout_cnt         <= '0;
            state               <= COLLECT;
          end
        end

        COLLECT: begin
          // A byte arriving on the limit cycle takes priority over the abort.
          if (data_valid) begin
            timeout_cnt <= '0;
            if (byte_cnt == CNT_LAST) begin
              chk_reg <= data_in;
              state   <= CHECK;
            end else begin
              shadow[int'(byte_cnt)*DATA_W +: DATA_W] <= data_in;
              xor_acc  <= xor_acc ^ data_in;
              byte_cnt <= byte_cnt + CNT_FIRST;
            end
          end else if (timeout_cnt == TO_LIMIT) begin
            state       <= IDLE;
            byte_cnt    <= '0;
            xor_acc     <= '0;
            timeout_cnt <= '0;
            to_pulse    <= 1'b1;
          end else begin
            timeout_cnt <= timeout_cnt + 1'b1;
          end
        end

        CHECK: begin
          if (xor_acc == chk_reg) begin
            par_bus   <= shadow;
            par_valid <= 1'b1;
            upd_pulse <= 1'b1;
          end else begin
            crc_err_pulse <= 1'b1;
          end

          // The shadow copy into par_bus above uses the pre-edge shadow value,
          // so a new frame's first byte can be captured in the same cycle.
          if (data_valid) begin
            shadow[0 +: DATA_W] <= data_in;
            xor_acc             <= data_in;
            byte_cnt            <= CNT_FIRST;
            timeout_cnt         <= '0;
            state               <= COLLECT;
          end else begin
            xor_acc     <= '0;
            byte_cnt    <= '0;
            timeout_cnt <= '0;
            state       <= IDLE;
          end
        end

        default: begin
          state       <= IDLE;
          byte_cnt    <= '0;
          xor_acc     <= '0;
          timeout_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conf_reg_bank.sv
module tb_conf_reg_bank;

  localparam int W  = 8;
  localparam int N  = 5;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [W-1:0]   data_in = '0;
  logic           data_valid = 1'b0;
  logic [N*W-1:0] par_bus;
  logic           par_valid;
  logic           upd_pulse;
  logic           crc_err_pulse;
  logic           to_pulse;

  conf_reg_bank #(
    .DATA_W(W), .PAR_NUM(N), .TIMEOUT_MAX(TO), .PAR_DEFAULT('0)
  ) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .par_bus(par_bus), .par_valid(par_valid), .upd_pulse(upd_pulse),
    .crc_err_pulse(crc_err_pulse), .to_pulse(to_pulse)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int upd_seen = 0, crc_seen = 0, to_seen = 0;
  int exp_upd = 0, exp_crc = 0, exp_to = 0;
  logic [N*W-1:0] exp_par = '0;
  logic           exp_valid = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse monitor: counts pulses and checks mutual exclusivity mid-cycle.
  always @(negedge clk) begin
    if (upd_pulse === 1'b1) upd_seen++;
    if (crc_err_pulse === 1'b1) crc_seen++;
    if (to_pulse === 1'b1) to_seen++;
    if ((upd_pulse | crc_err_pulse | to_pulse) === 1'b1)
      check("pulse_exclusive", 64'($countones({upd_pulse, crc_err_pulse, to_pulse})), 64'd1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [W-1:0] b);
    data_in    = b;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
  endtask

  task automatic send_data(input logic [N*W-1:0] f, input int gap);
    for (int i = 0; i < N; i++) begin
      send_byte(f[i*W +: W]);
      idle(gap);
    end
  endtask

  function automatic logic [W-1:0] xor_of(input logic [N*W-1:0] f);
    logic [W-1:0] x = '0;
    for (int i = 0; i < N; i++) x = x ^ f[i*W +: W];
    return x;
  endfunction

  task automatic check_state(input string tag);
    check({tag, "_par_bus"}, 64'(par_bus), 64'(exp_par));
    check({tag, "_par_valid"}, 64'(par_valid), 64'(exp_valid));
    check({tag, "_upd_cnt"}, 64'(upd_seen), 64'(exp_upd));
    check({tag, "_crc_cnt"}, 64'(crc_seen), 64'(exp_crc));
    check({tag, "_to_cnt"}, 64'(to_seen), 64'(exp_to));
  endtask

  logic [N*W-1:0] fa, fb, fr;
  logic [W-1:0]   chk;
  bit             good;
  int             gap;

  initial begin
    // reset
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    check("rst_upd", 64'(upd_pulse), 64'd0);
    check("rst_crc", 64'(crc_err_pulse), 64'd0);
    check("rst_to", 64'(to_pulse), 64'd0);
    check_state("reset");

    // good frame with exact latency
    fa = 40'h5544332211;
    send_data(fa, 3);
    send_byte(8'h11);
    check("good_check_cycle_upd", 64'(upd_pulse), 64'd0);
    check("good_check_cycle_bus", 64'(par_bus), 64'd0);
    tick();
    check("good_upd_pulse", 64'(upd_pulse), 64'd1);
    check("good_bus_now", 64'(par_bus), 64'h5544332211);
    tick();
    check("good_upd_drop", 64'(upd_pulse), 64'd0);
    exp_par = fa; exp_valid = 1'b1; exp_upd++;
    idle(2);
    check_state("good");

    // bad checksum
    send_data(fa, 3);
    send_byte(8'h12);
    tick();
    check("bad_crc_pulse", 64'(crc_err_pulse), 64'd1);
    tick();
    check("bad_crc_drop", 64'(crc_err_pulse), 64'd0);
    exp_crc++;
    idle(2);
    check_state("bad");

    // timeout: abort only after the counter has sat at the limit
    send_byte(8'hAA);
    idle(3);
    send_byte(8'hBB);
    idle(TO);
    check("to_not_yet", 64'(to_seen), 64'(exp_to));
    tick();
    check("to_pulse_high", 64'(to_pulse), 64'd1);
    tick();
    check("to_pulse_drop", 64'(to_pulse), 64'd0);
    exp_to++;
    fa = 40'h0504030201;
    send_data(fa, 3);
    send_byte(8'h01);
    idle(3);
    exp_par = fa; exp_upd++;
    check_state("after_to");

    // boundary: byte on the limit cycle is accepted
    send_byte(8'h10);
    idle(TO);
    send_byte(8'h77);
    idle(3);
    send_byte(8'h30); idle(3);
    send_byte(8'h40); idle(3);
    send_byte(8'h50); idle(3);
    fa = 40'h5040307710;
    send_byte(xor_of(fa));
    idle(3);
    exp_par = fa; exp_upd++;
    check_state("boundary");

    // back-to-back: next frame's first byte in the CHECK cycle
    fa = 40'hA5A4A3A2A1;
    fb = 40'hB5B4B3B2B1;
    send_data(fa, 3);
    send_byte(xor_of(fa));
    send_byte(fb[0 +: W]);
    check("b2b_first_commit", 64'(par_bus), 64'(fa));
    idle(3);
    for (int i = 1; i < N; i++) begin
      send_byte(fb[i*W +: W]);
      idle(3);
    end
    send_byte(xor_of(fb));
    idle(3);
    exp_par = fb; exp_upd += 2;
    check_state("b2b");

    // reset mid-frame
    send_byte(8'hC1); idle(3);
    send_byte(8'hC2); idle(3);
    send_byte(8'hC3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_par = '0; exp_valid = 1'b0;
    idle(TO + 4);
    check_state("mid_rst");
    fa = 40'h0A0B0C0D0E;
    send_data(fa, 3);
    send_byte(xor_of(fa));
    idle(3);
    exp_par = fa; exp_valid = 1'b1; exp_upd++;
    check_state("after_rst");

    // randomized frames against the reference model
    for (int k = 0; k < 20; k++) begin
      fr   = {$urandom, $urandom};
      good = ($urandom_range(0, 3) != 0);
      gap  = $urandom_range(0, TO - 1);
      chk  = xor_of(fr);
      if (!good) chk = chk ^ (W'(1) << $urandom_range(0, W - 1));
      send_data(fr, gap);
      send_byte(chk);
      idle(3);
      if (good) begin
        exp_par = fr; exp_valid = 1'b1; exp_upd++;
      end else begin
        exp_crc++;
      end
      check_state("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
